// File: rtl/qed_commit_tracker.sv
// qed_commit_tracker: classifies retiring instructions as original/duplicate and tracks QED commit counts and SIF phase
module qed_commit_tracker #(
  parameter int CNT_WIDTH  = 16,
  parameter int NUM_COMMIT = 2,
  parameter int REG_HALF   = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    qed_enable_i,
  input  logic [NUM_COMMIT-1:0]   commit_valid_i,
  input  logic [NUM_COMMIT*5-1:0] commit_rd_i,
  input  logic [NUM_COMMIT-1:0]   commit_we_i,
  input  logic [NUM_COMMIT-1:0]   commit_ex_i,
  output logic [CNT_WIDTH-1:0]    qed_num_orig_o,
  output logic [CNT_WIDTH-1:0]    qed_num_dup_o,
  output logic [1:0]              sif_state_o,
  output logic                    sif_commit_o,
  output logic                    qed_ready_o,
  output logic                    qed_overflow_o
);
  typedef enum logic [1:0] {IDLE, ORIG, DUP, ERR} state_t;
  localparam logic [CNT_WIDTH-1:0] MAX = {CNT_WIDTH{1'b1}};
  state_t state_q, s;
  logic [CNT_WIDTH-1:0] o, d;
  logic [4:0] rd;
  logic ov, cm, ex_any, cnt, is_dup;
  always_comb begin
    s = state_q;
    o = qed_num_orig_o;
    d = qed_num_dup_o;
    ov = qed_overflow_o;
    cm = 1'b0;
    ex_any = 1'b0;
    rd = '0;
    cnt = 1'b0;
    is_dup = 1'b0;
    for (int j = 0; j < NUM_COMMIT; j++) begin
      rd = commit_rd_i[5*j +: 5];
      cnt = commit_valid_i[j] & commit_we_i[j] & (rd != 5'd0) & ~commit_ex_i[j];
      is_dup = int'(rd) >= REG_HALF;
      ex_any = ex_any | (commit_valid_i[j] & commit_ex_i[j]);
      if (cnt) begin
        ov = ov | (is_dup ? d == MAX : o == MAX);
        d = (is_dup && d != MAX) ? d + 1'b1 : d;
        o = (!is_dup && o != MAX) ? o + 1'b1 : o;
        s = (s == ERR) ? ERR : is_dup ? ((s == IDLE) ? ERR : DUP) : ((s == DUP) ? ERR : ORIG);
        cm = cm | (s == DUP && d == o);
        s = (s == DUP && d == o) ? IDLE : (s == DUP && d > o) ? ERR : s;
      end
    end
    s = ex_any ? ERR : s;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      qed_num_orig_o <= '0;
      qed_num_dup_o <= '0;
      qed_overflow_o <= 1'b0;
      sif_commit_o <= 1'b0;
      qed_ready_o <= 1'b0;
    end else if (qed_enable_i) begin
      state_q <= s;
      qed_num_orig_o <= o;
      qed_num_dup_o <= d;
      qed_overflow_o <= ov;
      sif_commit_o <= cm;
      qed_ready_o <= s == IDLE && o == d && o != '0;
    end else begin
      sif_commit_o <= 1'b0;
    end
  end
  assign sif_state_o = state_q;
endmodule

// File: tb/tb_qed_commit_tracker.sv
// tb_qed_commit_tracker: directed self-checking bench for qed_commit_tracker
module tb_qed_commit_tracker;
  logic clk_i = 1'b0;
  logic rst_ni = 1'b0;
  logic qed_enable_i = 1'b1;
  logic [1:0] commit_valid_i = '0;
  logic [9:0] commit_rd_i = '0;
  logic [1:0] commit_we_i = '0;
  logic [1:0] commit_ex_i = '0;
  logic [15:0] orig, dup;
  logic [1:0] state;
  logic sif, ready, ovf;
  logic [3:0] s_orig, s_dup;
  logic [1:0] s_state;
  logic s_sif, s_ready, s_ovf;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk_i = ~clk_i;
  qed_commit_tracker dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .qed_enable_i(qed_enable_i),
    .commit_valid_i(commit_valid_i), .commit_rd_i(commit_rd_i),
    .commit_we_i(commit_we_i), .commit_ex_i(commit_ex_i),
    .qed_num_orig_o(orig), .qed_num_dup_o(dup), .sif_state_o(state),
    .sif_commit_o(sif), .qed_ready_o(ready), .qed_overflow_o(ovf)
  );
  qed_commit_tracker #(.CNT_WIDTH(4)) sat (
    .clk_i(clk_i), .rst_ni(rst_ni), .qed_enable_i(qed_enable_i),
    .commit_valid_i(commit_valid_i), .commit_rd_i(commit_rd_i),
    .commit_we_i(commit_we_i), .commit_ex_i(commit_ex_i),
    .qed_num_orig_o(s_orig), .qed_num_dup_o(s_dup), .sif_state_o(s_state),
    .sif_commit_o(s_sif), .qed_ready_o(s_ready), .qed_overflow_o(s_ovf)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic drive(input logic en, input logic [1:0] v, input logic [4:0] r0, input logic [4:0] r1,
                       input logic [1:0] w, input logic [1:0] x);
    @(negedge clk_i);
    qed_enable_i = en;
    commit_valid_i = v;
    commit_rd_i = {r1, r0};
    commit_we_i = w;
    commit_ex_i = x;
    @(posedge clk_i);
    #1;
  endtask
  task automatic orig1(input logic [4:0] r);
    drive(1'b1, 2'b01, r, 5'd0, 2'b01, 2'b00);
  endtask
  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    qed_enable_i = 1'b1;
    commit_valid_i = 2'b11;
    commit_rd_i = {5'd20, 5'd5};
    commit_we_i = 2'b11;
    commit_ex_i = 2'b00;
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    rst_ni = 1'b1;
    commit_valid_i = '0;
  endtask
  task automatic chk_cs(input string tag, input int eo, input int ed, input int es);
    chk({tag, "_orig"}, 32'(orig), 32'(eo));
    chk({tag, "_dup"}, 32'(dup), 32'(ed));
    chk({tag, "_state"}, 32'(state), 32'(es));
  endtask
  initial begin
    orig1(5'd5);
    do_reset();
    chk_cs("rst", 0, 0, 0);
    chk("rst_sif", 32'(sif), 0);
    chk("rst_ready", 32'(ready), 0);
    chk("rst_ovf", 32'(ovf), 0);
    drive(1'b1, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00);
    chk("post_rst_ready", 32'(ready), 0);
    orig1(5'd5);
    chk_cs("blk1", 1, 0, 1);
    orig1(5'd6);
    chk_cs("blk2", 2, 0, 1);
    orig1(5'd21);
    chk_cs("blk3", 2, 1, 2);
    chk("blk3_sif", 32'(sif), 0);
    orig1(5'd22);
    chk_cs("blk4", 2, 2, 0);
    chk("blk4_sif", 32'(sif), 1);
    chk("blk4_ready", 32'(ready), 1);
    drive(1'b1, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00);
    chk("blk5_sif", 32'(sif), 0);
    chk("blk5_ready", 32'(ready), 1);
    drive(1'b0, 2'b01, 5'd9, 5'd0, 2'b01, 2'b00);
    chk_cs("en_lo_idle", 2, 2, 0);
    chk("en_lo_ready", 32'(ready), 1);
    do_reset();
    orig1(5'd5);
    chk_cs("dual0", 1, 0, 1);
    drive(1'b1, 2'b11, 5'd20, 5'd3, 2'b11, 2'b00);
    chk_cs("dual1", 2, 1, 1);
    chk("dual1_sif", 32'(sif), 1);
    chk("dual1_ready", 32'(ready), 0);
    drive(1'b1, 2'b01, 5'd0, 5'd0, 2'b01, 2'b00);
    chk_cs("rd0", 2, 1, 1);
    chk("rd0_sif", 32'(sif), 0);
    drive(1'b1, 2'b01, 5'd7, 5'd0, 2'b00, 2'b00);
    chk_cs("we0", 2, 1, 1);
    drive(1'b1, 2'b10, 5'd0, 5'd18, 2'b00, 2'b00);
    chk_cs("we0_l1", 2, 1, 1);
    drive(1'b0, 2'b11, 5'd7, 5'd19, 2'b11, 2'b00);
    chk_cs("en0", 2, 1, 1);
    drive(1'b1, 2'b01, 5'd8, 5'd0, 2'b01, 2'b01);
    chk_cs("exc", 2, 1, 3);
    orig1(5'd9);
    chk_cs("err_abs", 3, 1, 3);
    do_reset();
    orig1(5'd17);
    chk_cs("idle_dup", 0, 1, 3);
    do_reset();
    orig1(5'd4);
    orig1(5'd9);
    orig1(5'd18);
    chk_cs("in_dup", 2, 1, 2);
    orig1(5'd4);
    chk_cs("interleave", 3, 1, 3);
    do_reset();
    orig1(5'd1);
    drive(1'b1, 2'b11, 5'd16, 5'd17, 2'b11, 2'b00);
    chk_cs("dup_gt", 1, 2, 3);
    chk("dup_gt_sif", 32'(sif), 1);
    do_reset();
    for (int i = 0; i < 15; i++) orig1(5'd1);
    chk("sat15_orig", 32'(s_orig), 15);
    chk("sat15_ovf", 32'(s_ovf), 0);
    orig1(5'd1);
    chk("sat16_orig", 32'(s_orig), 15);
    chk("sat16_ovf", 32'(s_ovf), 1);
    chk("wide16_orig", 32'(orig), 16);
    chk("wide16_ovf", 32'(ovf), 0);
    drive(1'b1, 2'b00, 5'd0, 5'd0, 2'b00, 2'b00);
    chk("sat_sticky", 32'(s_ovf), 1);
    chk("sat_hold", 32'(s_orig), 15);
    do_reset();
    chk("sat_rst_ovf", 32'(s_ovf), 0);
    chk("sat_rst_orig", 32'(s_orig), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
